mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_ctrl_if.sv | 22 ++
 rtl/mem_ctrl_arb.sv | 21 ++
 rtl/mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory controller: FSM state encoding, port-select codes, word width.
// No logic; imported by the controller, its arbiter and the bus interface users.
package mem_ctrl_pkg;

    localparam int WORD_WIDTH = 32;

    localparam int MC_STATE_W = 2;
    typedef enum logic [MC_STATE_W-1:0] {
        MC_IDLE = 2'd0,
        MC_BUS  = 2'd1,
        MC_RESP = 2'd2
    } mc_state_t;

    // Select code doubles as the bit index into the pending-flag vector.
    localparam int MC_SEL_W = 2;
    typedef enum logic [MC_SEL_W-1:0] {
        MC_SEL_FETCH = 2'd0,
        MC_SEL_LOAD  = 2'd1,
        MC_SEL_STORE = 2'd2
    } mc_sel_t;

    function automatic logic [2:0] sel_onehot(mc_sel_t s);
        return 3'b001 << s;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Shared word-wide external bus with req/ack handshake.
// Master holds req/we/addr/wdata stable until ack; slave returns rdata with a one-cycle ack.
interface mem_ctrl_if #(
    parameter int W = 32
) ();
    logic         bus_req;
    logic         bus_we;
    logic [W-1:0] bus_addr;
    logic [W-1:0] bus_wdata;
    logic         bus_ack;
    logic [W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Fixed-priority picker over the pending flags: store > load > fetch.
// Purely combinational, zero latency; no backpressure of its own.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic [2:0] pend_i,
    output mc_sel_t    grant_o,
    output logic       any_o
);

    always_comb begin
        grant_o = MC_SEL_FETCH;
        if (pend_i[MC_SEL_STORE])
            grant_o = MC_SEL_STORE;
        else if (pend_i[MC_SEL_LOAD])
            grant_o = MC_SEL_LOAD;
    end

    assign any_o = |pend_i;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: fetch/load/store ports arbitrated onto one req/ack bus with timeout.
// Latency: en edge -> bus_req after 1 cycle, done the cycle after ack; optional MEM_CTRL_FETCH_BUF_EN buffer.
// Backpressure: requests queue as one pending flag per port; edges on a pending port are dropped.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int W       = WORD_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_en,
    input  logic [W-1:0]  pc,
    output logic [W-1:0]  read_inst,
    output logic          inst_done,
    input  logic          load_en,
    input  logic [W-1:0]  l_addr,
    output logic [W-1:0]  l_data,
    output logic          load_done,
    input  logic          store_en,
    input  logic [W-1:0]  s_addr,
    input  logic [W-1:0]  s_data,
    output logic          store_done,
    output logic          busy,
    output logic          bus_err,
    mem_ctrl_if.master    bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mc_state_t    state_q;
    mc_sel_t      sel_q, grant;
    logic         any, launch;
    logic [2:0]   en_now, en_prev_q, edge_w, pend_q, pend_clr;
    logic [W-1:0] pc_lat_q, l_addr_lat_q, s_addr_lat_q, s_data_lat_q, launch_addr;
    logic [W-1:0] read_inst_q, l_data_q, bus_addr_q, bus_wdata_q;
    logic         bus_req_q, bus_we_q, inst_done_q, load_done_q, store_done_q, bus_err_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic         timeout;
    logic         fb_hit;
    logic [W-1:0] fb_inst;

    mem_ctrl_arb u_arb (
        .pend_i  (pend_q),
        .grant_o (grant),
        .any_o   (any)
    );

    assign en_now   = {store_en, load_en, pc_en};
    assign edge_w   = en_now & ~en_prev_q;
    assign launch   = (state_q == MC_IDLE) && any;
    assign pend_clr = launch ? sel_onehot(grant) : 3'b000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_prev_q    <= '0;
            pend_q       <= '0;
            pc_lat_q     <= '0;
            l_addr_lat_q <= '0;
            s_addr_lat_q <= '0;
            s_data_lat_q <= '0;
        end else begin
            en_prev_q <= en_now;
            pend_q    <= (pend_q & ~pend_clr) | (edge_w & ~pend_q);
            if (edge_w[MC_SEL_FETCH] && !pend_q[MC_SEL_FETCH])
                pc_lat_q <= pc;
            if (edge_w[MC_SEL_LOAD] && !pend_q[MC_SEL_LOAD])
                l_addr_lat_q <= l_addr;
            if (edge_w[MC_SEL_STORE] && !pend_q[MC_SEL_STORE]) begin
                s_addr_lat_q <= s_addr;
                s_data_lat_q <= s_data;
            end
        end
    end

    always_comb begin
        case (grant)
            MC_SEL_LOAD:  launch_addr = l_addr_lat_q;
            MC_SEL_STORE: launch_addr = s_addr_lat_q;
            default:      launch_addr = pc_lat_q;
        endcase
    end

    // Saturating count; ack is checked first so an ack on the last cycle is not an error.
    assign cnt_inc = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
    assign timeout = (cnt_inc == CNT_W'(TIMEOUT));

`ifdef MEM_CTRL_FETCH_BUF_EN
    logic [W-1:0] fb_tag_q, fb_inst_q;
    logic         fb_vld_q;

    assign fb_hit  = launch && (grant == MC_SEL_FETCH) && fb_vld_q && (pc_lat_q == fb_tag_q);
    assign fb_inst = fb_inst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fb_tag_q  <= '0;
            fb_inst_q <= '0;
            fb_vld_q  <= 1'b0;
        end else if (state_q == MC_BUS && bus.bus_ack && sel_q == MC_SEL_FETCH) begin
            fb_tag_q  <= bus_addr_q;
            fb_inst_q <= bus.bus_rdata;
            fb_vld_q  <= 1'b1;
        end else if (launch && grant == MC_SEL_STORE && s_addr_lat_q == fb_tag_q) begin
            fb_vld_q  <= 1'b0;
        end
    end
`else
    assign fb_hit  = 1'b0;
    assign fb_inst = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= MC_IDLE;
            sel_q        <= MC_SEL_FETCH;
            cnt_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            read_inst_q  <= '0;
            l_data_q     <= '0;
            inst_done_q  <= 1'b0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            inst_done_q  <= 1'b0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                MC_IDLE: begin
                    if (any) begin
                        sel_q <= grant;
                        if (fb_hit) begin
                            state_q     <= MC_RESP;
                            inst_done_q <= 1'b1;
                            read_inst_q <= fb_inst;
                        end else begin
                            state_q     <= MC_BUS;
                            cnt_q       <= '0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= (grant == MC_SEL_STORE);
                            bus_addr_q  <= launch_addr;
                            bus_wdata_q <= (grant == MC_SEL_STORE) ? s_data_lat_q : '0;
                        end
                    end
                end
                MC_BUS: begin
                    if (bus.bus_ack || timeout) begin
                        state_q   <= MC_RESP;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        bus_err_q <= !bus.bus_ack;
                        case (sel_q)
                            MC_SEL_STORE: store_done_q <= 1'b1;
                            MC_SEL_LOAD: begin
                                load_done_q <= 1'b1;
                                l_data_q    <= bus.bus_ack ? bus.bus_rdata : '0;
                            end
                            default: begin
                                inst_done_q <= 1'b1;
                                read_inst_q <= bus.bus_ack ? bus.bus_rdata : '0;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= MC_IDLE;
            endcase
        end
    end

    assign busy          = (|pend_q) || (state_q != MC_IDLE);
    assign read_inst     = read_inst_q;
    assign l_data        = l_data_q;
    assign inst_done     = inst_done_q;
    assign load_done     = load_done_q;
    assign store_done    = store_done_q;
    assign bus_err       = bus_err_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a RAM-backed slave of programmable ack delay, TIMEOUT=4.
// Exercises fetch, store/load, simultaneous requests, timeout, ack-vs-timeout, async reset, fetch buffer.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en, load_en, store_en;
    logic [31:0] pc, l_addr, s_addr, s_data;
    logic [31:0] read_inst, l_data;
    logic        inst_done, load_done, store_done, busy, bus_err;

    mem_ctrl_if #(.W(32)) bus_if ();

    mem_ctrl #(.W(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_en      (pc_en),
        .pc         (pc),
        .read_inst  (read_inst),
        .inst_done  (inst_done),
        .load_en    (load_en),
        .l_addr     (l_addr),
        .l_data     (l_data),
        .load_done  (load_done),
        .store_en   (store_en),
        .s_addr     (s_addr),
        .s_data     (s_data),
        .store_done (store_done),
        .busy       (busy),
        .bus_err    (bus_err),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    // Slave: acks after ack_delay idle cycles of an asserted request.
    logic [31:0] ram [logic [31:0]];
    logic        sl_en = 1'b0;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        ack_given = 1'b0;
    logic        sl_ack = 1'b0;
    logic [31:0] sl_rdata = '0;

    assign bus_if.bus_ack   = sl_ack;
    assign bus_if.bus_rdata = sl_rdata;

    always @(negedge clk) begin
        if (!bus_if.bus_req || ack_given) begin
            sl_ack = 1'b0;
            if (!bus_if.bus_req) begin
                wcnt      = 0;
                ack_given = 1'b0;
            end
        end else if (sl_en) begin
            if (wcnt == ack_delay) begin
                sl_ack    = 1'b1;
                ack_given = 1'b1;
                if (bus_if.bus_we)
                    ram[bus_if.bus_addr] = bus_if.bus_wdata;
                else
                    sl_rdata = ram.exists(bus_if.bus_addr) ? ram[bus_if.bus_addr] : 32'h0;
            end else begin
                wcnt++;
            end
        end
    end

    logic [31:0] log_addr[$];
    logic        log_we[$];
    always @(posedge clk) begin
        if (bus_if.bus_req && bus_if.bus_ack) begin
            log_addr.push_back(bus_if.bus_addr);
            log_we.push_back(bus_if.bus_we);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pc_en = 1'b0; load_en = 1'b0; store_en = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st_n, ld_n, if_n, st_c, ld_c, if_c;
        logic b8, b9;

        ram[32'h40]  = 32'h2402_0005;
        ram[32'h200] = 32'h1111_0000;
        rst = 1'b0; pc_en = 0; load_en = 0; store_en = 0;
        pc = '0; l_addr = '0; s_addr = '0; s_data = '0;
        tick();
        chk("rst_req", bus_if.bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inst", read_inst, 0);
        chk("rst_addr", bus_if.bus_addr, 0);
        tick();
        rst = 1'b1;
        idle(2);

        // Single fetch, ack after 2 cycles.
        sl_en = 1; ack_delay = 2;
        pc = 32'h40; pc_en = 1;
        tick();
        chk("f_req_e0", bus_if.bus_req, 0);
        chk("f_busy_e0", busy, 1);
        tick();
        chk("f_req_e1", bus_if.bus_req, 1);
        chk("f_we", bus_if.bus_we, 0);
        chk("f_addr", bus_if.bus_addr, 32'h40);
        tick(); tick();
        chk("f_done_e3", inst_done, 0);
        tick();
        chk("f_done_e4", inst_done, 1);
        chk("f_inst", read_inst, 32'h2402_0005);
        chk("f_req_drop", bus_if.bus_req, 0);
        tick();
        chk("f_done_e5", inst_done, 0);
        chk("f_busy_e5", busy, 0);
        idle(2);

        // Store then load back through the RAM.
        ack_delay = 0;
        s_addr = 32'h100; s_data = 32'hDEAD_BEEF; store_en = 1;
        tick(); tick();
        chk("s_we", bus_if.bus_we, 1);
        chk("s_addr", bus_if.bus_addr, 32'h100);
        chk("s_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
        tick();
        chk("s_done", store_done, 1);
        idle(2);
        l_addr = 32'h100; load_en = 1;
        tick(); tick();
        chk("l_we", bus_if.bus_we, 0);
        chk("l_addr", bus_if.bus_addr, 32'h100);
        tick();
        chk("l_done", load_done, 1);
        chk("l_data", l_data, 32'hDEAD_BEEF);
        idle(2);

        // Three requests in one cycle, enables held high throughout.
        log_addr.delete(); log_we.delete();
        pc = 32'h200; l_addr = 32'h100; s_addr = 32'h300; s_data = 32'h33;
        pc_en = 1; load_en = 1; store_en = 1;
        st_n = 0; ld_n = 0; if_n = 0; st_c = -1; ld_c = -1; if_c = -1; b8 = 0; b9 = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (store_done) begin st_n++; st_c = i; end
            if (load_done)  begin ld_n++; ld_c = i; end
            if (inst_done)  begin if_n++; if_c = i; end
            if (i == 8) b8 = busy;
            if (i == 9) b9 = busy;
        end
        chk("m_st_cnt", st_n, 1);
        chk("m_ld_cnt", ld_n, 1);
        chk("m_if_cnt", if_n, 1);
        chk("m_st_cyc", st_c, 2);
        chk("m_ld_cyc", ld_c, 5);
        chk("m_if_cyc", if_c, 8);
        chk("m_busy8", b8, 1);
        chk("m_busy9", b9, 0);
        chk("m_ntx", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("m_tx0", {log_we[0], log_addr[0][30:0]}, 32'h8000_0300);
            chk("m_tx1", {log_we[1], log_addr[1][30:0]}, 32'h0000_0100);
            chk("m_tx2", {log_we[2], log_addr[2][30:0]}, 32'h0000_0200);
        end
        chk("m_ldata", l_data, 32'hDEAD_BEEF);
        chk("m_inst", read_inst, 32'h1111_0000);
        idle(2);

        // No ack: abort after 4 BUS cycles.
        sl_en = 0;
        l_addr = 32'h100; load_en = 1;
        repeat (5) tick();
        chk("t_req_e4", bus_if.bus_req, 1);
        chk("t_err_e4", bus_err, 0);
        tick();
        chk("t_err_e5", bus_err, 1);
        chk("t_done_e5", load_done, 1);
        chk("t_ldata", l_data, 0);
        chk("t_req_e5", bus_if.bus_req, 0);
        tick();
        chk("t_err_e6", bus_err, 0);
        idle(2);

        // Ack lands on the same cycle the timeout would fire.
        sl_en = 1; ack_delay = 3;
        l_addr = 32'h300; load_en = 1;
        repeat (5) tick();
        chk("at_done_e4", load_done, 0);
        tick();
        chk("at_done_e5", load_done, 1);
        chk("at_err", bus_err, 0);
        chk("at_ldata", l_data, 32'h33);
        idle(2);

        // Asynchronous reset in the middle of a bus transaction.
        sl_en = 0;
        pc = 32'h40; pc_en = 1;
        tick(); tick();
        chk("r_req_pre", bus_if.bus_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("r_req", bus_if.bus_req, 0);
        chk("r_addr", bus_if.bus_addr, 0);
        chk("r_inst", read_inst, 0);
        chk("r_ldata", l_data, 0);
        chk("r_busy", busy, 0);
        pc_en = 0;
        tick();
        rst = 1'b1;
        idle(1);
        sl_en = 1; ack_delay = 1;
        pc_en = 1;
        tick(); tick();
        chk("r2_req", bus_if.bus_req, 1);
        tick();
        chk("r2_done_e2", inst_done, 0);
        tick();
        chk("r2_done_e3", inst_done, 1);
        chk("r2_inst", read_inst, 32'h2402_0005);
        idle(2);

        // Repeat fetch of the same address, then invalidate by a store.
        ack_delay = 0;
        pc_en = 1;
        tick(); tick();
`ifdef MEM_CTRL_FETCH_BUF_EN
        chk("b_req", bus_if.bus_req, 0);
        chk("b_done_e1", inst_done, 1);
        chk("b_inst", read_inst, 32'h2402_0005);
        tick();
        chk("b_busy_e2", busy, 0);
`else
        chk("b_req", bus_if.bus_req, 1);
        chk("b_done_e1", inst_done, 0);
        tick();
        chk("b_done_e2", inst_done, 1);
        chk("b_inst", read_inst, 32'h2402_0005);
`endif
        idle(2);
        s_addr = 32'h40; s_data = 32'h55; store_en = 1;
        repeat (3) tick();
        chk("b_sdone", store_done, 1);
        idle(2);
        pc_en = 1;
        tick(); tick();
        chk("b2_req", bus_if.bus_req, 1);
        tick();
        chk("b2_done", inst_done, 1);
        chk("b2_inst", read_inst, 32'h55);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
